// File: rtl/shape_processor_modeling_pkg.sv
// Shared shape-processor modelling types: the control SFR layout, its
// "keep current value" field encodings, and the command sequencer state enum.
package shape_processor_modeling;

  // Control SFR as seen by the shape processor. The sequencer moves the
  // whole word opaquely; the fields are named here for debug visibility.
  typedef struct packed {
    logic [23:0] reserved;
    logic [3:0]  operation;
    logic [3:0]  shape;
  } ctrl_sfr_reg;

  localparam int CTRL_W = $bits(ctrl_sfr_reg);

  // Field encodings that tell the shape processor to leave the field as is.
  localparam logic [3:0] KEEP_SHAPE     = 4'hF;
  localparam logic [3:0] KEEP_OPERATION = 4'hF;

  // Command sequencer FSM: write the head command, read the SFR back, repeat.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } shape_ctrl_seq_state_e;

  // True when a control word changes neither field. Informational only:
  // the processor itself decides whether a word is legal.
  function automatic logic is_keep_all(ctrl_sfr_reg w);
    return (w.shape == KEEP_SHAPE) && (w.operation == KEEP_OPERATION);
  endfunction

endpackage

// File: rtl/shape_cmd_fifo.sv
// Command FIFO: DEPTH x WIDTH circular buffer with occupancy count.
// Push is refused when full regardless of a same-cycle pop; pop is ignored
// when empty.
module shape_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q;
  logic [AW-1:0]               rd_ptr_q;
  logic [LW-1:0]               level_q;
  logic [LW-1:0]               level_d;
  logic                        push_ok;
  logic                        pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Occupancy: push and pop in the same cycle cancel out.
  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/shape_ctrl_sequencer.sv
// Shape control sequencer: queues control words and replays each one to the
// shape processor as a one-cycle write followed by a one-cycle SFR read-back,
// reporting the outcome with a done pulse and a saturating reject counter.
module shape_ctrl_sequencer
  import shape_processor_modeling::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_data,
  output logic                   write,
  output logic [31:0]            write_data,
  output logic                   read,
  input  logic [31:0]            read_data,
  input  logic                   error,
  output logic                   done_valid,
  output logic                   done_ok,
  output logic [31:0]            done_rdata,
  output logic [7:0]             err_count,
  output logic [$clog2(DEPTH):0] level
);

  shape_ctrl_seq_state_e state_q, state_d;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  ctrl_sfr_reg head;
  logic        has_work;

  logic        done_valid_q;
  logic        done_ok_q;
  logic [31:0] done_rdata_q;
  logic [7:0]  err_count_q;

  // Ready depends only on occupancy, so a full FIFO refuses even while popping.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign head      = ctrl_sfr_reg'(fifo_rdata);

  // Work is visible at the next edge if something is queued or arriving now;
  // this is what lets a push into an empty FIFO be written the next cycle.
  assign has_work  = !fifo_empty || fifo_push;

  shape_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CTRL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (cmd_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and processor strobes; write_data is forced to zero off-strobe.
  always_comb begin
    state_d    = state_q;
    write      = 1'b0;
    write_data = '0;
    read       = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (has_work) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        write      = 1'b1;
        write_data = head;
        fifo_pop   = 1'b1;
        state_d    = READ;
      end
      READ: begin
        read    = 1'b1;
        state_d = has_work ? WRITE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the processor's verdict in the READ cycle; report it next cycle
  // and hold it until the following completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid_q <= 1'b0;
      done_ok_q    <= 1'b0;
      done_rdata_q <= '0;
      err_count_q  <= '0;
    end else begin
      done_valid_q <= (state_q == READ);
      if (state_q == READ) begin
        done_ok_q    <= !error;
        done_rdata_q <= read_data;
        if (error && (err_count_q != 8'hFF)) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
    end
  end

  assign done_valid = done_valid_q;
  assign done_ok    = done_ok_q;
  assign done_rdata = done_rdata_q;
  assign err_count  = err_count_q;

endmodule
